fifo_rd_sched: RTL and testbench
================================

Name: fifo_rd_sched

Overview:
- Read-side burst scheduler for the 16-bit dual-clock FIFO, running entirely in the 150 MHz read domain.
- Decides when to drain the FIFO and how many words to pull: a full burst when enough words are present, a partial burst after a timeout.
- Issues rdreq to the FIFO and absorbs its 1-cycle read latency.
- Presents words to the downstream filter stage on a valid/ready interface through a 2-entry skid buffer.

Parameters:
- DW, 16, FIFO data width.
- AW, 3, width of rdusedw; FIFO depth = 2^AW = 8.
- BURST, 4, words per full burst; legal range 1..2^AW.
- TIMEOUT, 16, read-clock cycles a non-empty FIFO may wait before a partial burst is forced; must be >= 2.

Ports:
- clk_150  in  1  read-domain clock; all logic on its rising edge.
- aclr_n  in  1  asynchronous active-low reset.
- en  in  1  scheduler enable.
- flush  in  1  drain request; single-cycle pulse or level.
- rdempty  in  1  FIFO read-side empty.
- rdfull  in  1  FIFO read-side full.
- rdusedw  in  AW  FIFO read-side word count.
- q  in  DW  FIFO read data, valid 1 cycle after rdreq (normal mode, not show-ahead).
- rdreq  out  1  FIFO read request.
- dout  out  DW  data to filter.
- dout_valid  out  1  dout holds a word.
- dout_ready  in  1  downstream accepts dout.
- busy  out  1  state != IDLE, or skid buffer non-empty.
- underrun  out  1  sticky flag: a burst ended early on rdempty.
- burst_cnt  out  16  count of completed bursts (full or partial); wraps modulo 2^16.

Behaviour:
- Reset: async assert, sync-style release. All outputs are 0, state = IDLE, skid buffer empty, all counters 0.
- Level: lvl = rdfull ? 2^AW : rdusedw. rdusedw wraps to 0 when the FIFO is full, so rdfull must override it.
- Read issue rule: rdreq = S_rd & !rdempty & (occ + inflight < 2).
  - occ = skid entries (0..2).
  - inflight = rdreq registered one cycle.
  - S_rd = state is BURST with rd_cnt < len, or state is FLUSH.
  - Result: rdreq is never asserted on an empty FIFO and the skid buffer never overflows.
- Capture: the cycle after rdreq = 1, q is written into the skid buffer.
- Output: dout/dout_valid come from the skid head. A word pops when dout_valid & dout_ready. dout is held stable while dout_valid & !dout_ready.
- Simultaneous capture and pop in the same cycle: occupancy is unchanged and order is preserved (FIFO order).
- States:
  - IDLE: entered only when en = 1 and flush = 0.
    - lvl >= BURST: go to BURST, len = BURST.
    - else if !rdempty: go to WAIT, wait_cnt = 0.
  - WAIT: wait_cnt increments each cycle.
    - lvl >= BURST: go to BURST, len = BURST.
    - else if rdempty: go to IDLE.
    - else if wait_cnt == TIMEOUT-1: go to BURST, len = lvl (partial burst).
    - en = 0: go to IDLE.
  - BURST: rd_cnt increments on each rdreq.
    - rd_cnt reaches len: go to IDLE, burst_cnt + 1.
    - rdempty with rd_cnt < len and no read in flight: go to IDLE, underrun set, burst_cnt + 1.
    - en = 0 mid-burst: the burst completes first.
  - FLUSH: entered from any state on flush = 1, including mid-burst; any words already in flight are still captured.
    - Reads continue until rdempty and inflight = 0, then go to IDLE.
    - burst_cnt is not incremented.
- Priority when events coincide: flush > burst completion > new burst decision.
- underrun clears only on reset.
- Re-entry: from IDLE a new burst may start on the cycle immediately after returning to IDLE.
- Throughput: sustains 1 word/cycle when dout_ready stays high.

Test Plan:
- Reset, then 4 words written, en = 1, dout_ready = 1 -> rdreq high for 4 consecutive cycles; dout_valid for 4 cycles starting 1 cycle after the first rdreq; data in write order; burst_cnt = 1; underrun = 0.
- 2 words written, BURST = 4 -> state stays in WAIT for 16 cycles, then a partial burst of exactly 2 rdreq; burst_cnt = 1.
- FIFO full (8 words, rdusedw = 0, rdfull = 1) -> lvl taken as 8; two back-to-back bursts of 4; burst_cnt = 2; no rdreq while rdempty.
- dout_ready held low during a burst -> at most 2 rdreq before stalling; dout holds the first word; release -> remaining words delivered in order, none lost or duplicated.
- flush pulsed mid-burst with 6 words present -> all 6 words delivered, then IDLE; burst_cnt unchanged.
- aclr_n asserted mid-burst -> rdreq, dout_valid and busy go to 0 immediately; state = IDLE after release.

Source files
------------

// File: rtl/fifo_rd_sched.sv
// -----------------------------------------------------------------------------
// fifo_rd_sched
//   Read-side burst scheduler for a dual-clock FIFO, running entirely in the
//   read clock domain. It decides when to drain the FIFO: a full burst of BURST
//   words once that many are present, or a partial burst of whatever is there
//   after TIMEOUT cycles of waiting. It issues rdreq, absorbs the FIFO's one
//   cycle read latency and hands words downstream through a 2-entry skid buffer.
//
// Ports
//   clk_150     read-domain clock, rising edge
//   aclr_n      asynchronous active-low reset
//   en          scheduler enable
//   flush       drain request (pulse or level)
//   rdempty     FIFO empty
//   rdfull      FIFO full
//   rdusedw     FIFO word count (wraps to 0 when full)
//   q           FIFO read data, valid one cycle after rdreq
//   rdreq       FIFO read request
//   dout        word to the downstream stage
//   dout_valid  dout holds a word
//   dout_ready  downstream accepts dout
//   busy        scheduler active or words still held
//   underrun    sticky: a burst ended early because the FIFO ran dry
//   burst_cnt   completed bursts (full or partial), wraps
// -----------------------------------------------------------------------------
module fifo_rd_sched #(
    parameter int DW      = 16,
    parameter int AW      = 3,
    parameter int BURST   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic          clk_150,
    input  logic          aclr_n,
    input  logic          en,
    input  logic          flush,
    input  logic          rdempty,
    input  logic          rdfull,
    input  logic [AW-1:0] rdusedw,
    input  logic [DW-1:0] q,
    output logic          rdreq,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          busy,
    output logic          underrun,
    output logic [15:0]   burst_cnt
);

    localparam int CW  = AW + 1;            // holds 0..2^AW
    localparam int WCW = $clog2(TIMEOUT);

    localparam logic [CW-1:0]  LVL_MAX   = CW'(1 << AW);
    localparam logic [CW-1:0]  BURST_LEN = CW'(BURST);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
    localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST,
        S_FLUSH
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  len_q, len_d;
    logic [CW-1:0]  rd_cnt_q, rd_cnt_d, rd_cnt_nx;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [15:0]    burst_cnt_q, burst_cnt_d;
    logic           underrun_q, underrun_d;
    logic           inflight_q;

    // Skid buffer: two entries plus the word currently arriving on q, which
    // falls straight through to dout when the buffer is empty.
    logic [DW-1:0]  mem_q [2];
    logic [1:0]     occ_q, occ_d;
    logic           rd_ptr_q, rd_ptr_d;
    logic           wr_ptr;
    logic           pop_skid, push_skid;

    logic [CW-1:0]  lvl;
    logic [2:0]     pending;
    logic           s_rd;

    // rdusedw reads 0 on a full FIFO, so rdfull has to override it.
    assign lvl     = rdfull ? LVL_MAX : {1'b0, rdusedw};
    assign pending = {1'b0, occ_q} + {2'b00, inflight_q};
    assign s_rd    = ((state_q == S_BURST) && (rd_cnt_q < len_q)) || (state_q == S_FLUSH);
    // Counting the in-flight word against the two slots keeps the buffer from
    // ever overflowing, while still allowing one read per cycle when the
    // downstream drains every word as it falls through.
    assign rdreq   = s_rd && !rdempty && (pending < 3'd2);

    assign dout_valid = (occ_q != 2'd0) || inflight_q;
    assign dout       = (occ_q != 2'd0) ? mem_q[rd_ptr_q] : (inflight_q ? q : '0);
    assign pop_skid   = (occ_q != 2'd0) && dout_ready;
    // The arriving word is stored unless it went straight out this cycle.
    assign push_skid  = inflight_q && !((occ_q == 2'd0) && dout_ready);
    assign wr_ptr     = rd_ptr_q ^ occ_q[0];

    assign busy       = (state_q != S_IDLE) || dout_valid;
    assign underrun   = underrun_q;
    assign burst_cnt  = burst_cnt_q;

    always_comb begin
        occ_d = occ_q;
        case ({push_skid, pop_skid})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
        rd_ptr_d = pop_skid ? ~rd_ptr_q : rd_ptr_q;
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d     = state_q;
        len_d       = len_q;
        wait_cnt_d  = wait_cnt_q;
        burst_cnt_d = burst_cnt_q;
        underrun_d  = underrun_q;
        rd_cnt_nx   = rdreq ? rd_cnt_q + CNT_ONE : rd_cnt_q;
        rd_cnt_d    = rd_cnt_nx;

        if (flush) begin
            // Flush beats everything, including a burst finishing this cycle.
            state_d = S_FLUSH;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        if (lvl >= BURST_LEN) begin
                            state_d  = S_BURST;
                            len_d    = BURST_LEN;
                            rd_cnt_d = '0;
                        end else if (!rdempty) begin
                            state_d    = S_WAIT;
                            wait_cnt_d = '0;
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                    if (lvl >= BURST_LEN) begin
                        state_d  = S_BURST;
                        len_d    = BURST_LEN;
                        rd_cnt_d = '0;
                    end else if (rdempty) begin
                        state_d = S_IDLE;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_d  = S_BURST;
                        len_d    = lvl;
                        rd_cnt_d = '0;
                    end else if (!en) begin
                        state_d = S_IDLE;
                    end
                end
                S_BURST: begin
                    // en is ignored here: a started burst always runs out.
                    if (rd_cnt_nx == len_q) begin
                        state_d     = S_IDLE;
                        burst_cnt_d = burst_cnt_q + 16'd1;
                    end else if (rdempty && !inflight_q) begin
                        state_d     = S_IDLE;
                        underrun_d  = 1'b1;
                        burst_cnt_d = burst_cnt_q + 16'd1;
                    end
                end
                S_FLUSH: begin
                    if (rdempty && !inflight_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_150 or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            rd_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
            underrun_q  <= 1'b0;
            inflight_q  <= 1'b0;
            occ_q       <= '0;
            rd_ptr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            rd_cnt_q    <= rd_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            underrun_q  <= underrun_d;
            inflight_q  <= rdreq;
            occ_q       <= occ_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // NOTE: the data storage is deliberately left out of reset; occ_q gates
    // every read of it, so stale contents are never visible on dout.
    always_ff @(posedge clk_150) begin
        if (push_skid) begin
            mem_q[wr_ptr] <= q;
        end
    end

endmodule

// File: tb/tb_fifo_rd_sched.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_sched
//   Drives fifo_rd_sched from a queue-based model of the dual-clock FIFO and
//   checks every delivered word against the order in which words were written.
//   Directed scenarios cover burst timing, timeout, full FIFO, backpressure,
//   flush, reset and underrun; a randomized phase follows.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_rd_sched;

    localparam int DW      = 16;
    localparam int AW      = 3;
    localparam int BURST   = 4;
    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 1 << AW;

    logic          clk_150;
    logic          aclr_n     = 1'b0;
    logic          en         = 1'b0;
    logic          flush      = 1'b0;
    logic          rdempty    = 1'b1;
    logic          rdfull     = 1'b0;
    logic [AW-1:0] rdusedw    = '0;
    logic [DW-1:0] q          = '0;
    logic          dout_ready = 1'b0;
    logic          rdreq;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          busy;
    logic          underrun;
    logic [15:0]   burst_cnt;

    fifo_rd_sched #(
        .DW(DW), .AW(AW), .BURST(BURST), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_150    (clk_150),
        .aclr_n     (aclr_n),
        .en         (en),
        .flush      (flush),
        .rdempty    (rdempty),
        .rdfull     (rdfull),
        .rdusedw    (rdusedw),
        .q          (q),
        .rdreq      (rdreq),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .underrun   (underrun),
        .burst_cnt  (burst_cnt)
    );

    initial begin
        clk_150 = 1'b0;
        forever #5 clk_150 = ~clk_150;
    end

    int n_total = 0;
    int n_bad   = 0;

    logic [DW-1:0] fifo_m[$];   // words currently inside the FIFO
    logic [DW-1:0] sb[$];       // words owed downstream, in write order
    int            force_lvl = -1;
    logic [DW-1:0] first_w;

    int cyc, n_rd, n_deliv, first_rd, last_rd, first_vld, n_vld;
    int tot_rd, tot_deliv;
    logic          stall_prev;
    logic [DW-1:0] held_dout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic update_status();
        int n;
        n = fifo_m.size();
        rdempty = (n == 0);
        rdfull  = (n == DEPTH);
        rdusedw = (force_lvl >= 0) ? AW'(force_lvl) : AW'(n % DEPTH);
    endtask

    task automatic fifo_write(input logic [DW-1:0] w);
        fifo_m.push_back(w);
        sb.push_back(w);
        update_status();
    endtask

    task automatic clr_stats();
        cyc = 0; n_rd = 0; n_deliv = 0;
        first_rd = -1; last_rd = -1; first_vld = -1; n_vld = 0;
    endtask

    // One read-clock cycle: observe at the falling edge, then advance the FIFO
    // model just after the rising edge (q carries the word read last cycle).
    task automatic cycle();
        logic [DW-1:0] w;
        logic          rd_now;
        w = '0;
        @(negedge clk_150);
        if (fifo_m.size() == 0) check("rdreq_on_empty", rdreq, 0);
        if (stall_prev) begin
            check("stall_valid", dout_valid, 1);
            check("stall_hold", dout, held_dout);
        end
        if (dout_valid) begin
            if (first_vld < 0) first_vld = cyc;
            n_vld++;
        end
        if (dout_valid && dout_ready) begin
            check("word_owed", sb.size() > 0, 1);
            if (sb.size() > 0) check("dout_order", dout, sb.pop_front());
            n_deliv++;
            tot_deliv++;
        end
        stall_prev = dout_valid && !dout_ready;
        held_dout  = dout;
        rd_now     = rdreq;
        if (rd_now) begin
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            n_rd++;
            tot_rd++;
            if (fifo_m.size() > 0) w = fifo_m.pop_front();
        end
        check("skid_bound", (tot_rd - tot_deliv) <= 2, 1);
        cyc++;
        @(posedge clk_150);
        #1;
        if (rd_now) q = w;
        update_status();
    endtask

    task automatic do_reset();
        aclr_n = 1'b0;
        en = 1'b0; flush = 1'b0; dout_ready = 1'b0; q = '0;
        fifo_m.delete(); sb.delete(); force_lvl = -1;
        update_status();
        stall_prev = 1'b0; tot_rd = 0; tot_deliv = 0;
        repeat (2) @(posedge clk_150);
        @(negedge clk_150);
        aclr_n = 1'b1;
        @(posedge clk_150);
        #1;
        clr_stats();
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0] w;
            w = DW'($urandom());
            if (i == 0) first_w = w;
            fifo_write(w);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_rdreq", rdreq, 0);
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        check("rst_burst_cnt", burst_cnt, 0);

        // Full burst of 4 with downstream always ready
        load(4);
        en = 1'b1; dout_ready = 1'b1;
        repeat (20) cycle();
        check("b4_n_rd", n_rd, 4);
        check("b4_first_rd", first_rd, 1);
        check("b4_consec", last_rd - first_rd, 3);
        check("b4_vld_lat", first_vld - first_rd, 1);
        check("b4_n_vld", n_vld, 4);
        check("b4_n_deliv", n_deliv, 4);
        check("b4_burst_cnt", burst_cnt, 1);
        check("b4_underrun", underrun, 0);

        // Two words: wait out the timeout, then a partial burst of 2
        do_reset();
        load(2);
        en = 1'b1; dout_ready = 1'b1;
        repeat (9) cycle();
        check("to_busy_wait", busy, 1);
        check("to_no_rd_wait", n_rd, 0);
        repeat (20) cycle();
        check("to_first_rd", first_rd, 1 + TIMEOUT);
        check("to_n_rd", n_rd, 2);
        check("to_n_deliv", n_deliv, 2);
        check("to_burst_cnt", burst_cnt, 1);

        // Full FIFO: rdusedw reads 0, two back-to-back bursts
        do_reset();
        load(DEPTH);
        check("full_rdusedw", rdusedw, 0);
        en = 1'b1; dout_ready = 1'b1;
        repeat (25) cycle();
        check("full_n_rd", n_rd, 8);
        check("full_first_rd", first_rd, 1);
        check("full_last_rd", last_rd, 9);
        check("full_n_deliv", n_deliv, 8);
        check("full_burst_cnt", burst_cnt, 2);

        // Backpressure: two reads then stall, first word held
        do_reset();
        load(4);
        en = 1'b1; dout_ready = 1'b0;
        repeat (10) cycle();
        check("bp_n_rd_stall", n_rd, 2);
        check("bp_valid", dout_valid, 1);
        check("bp_dout_first", dout, first_w);
        dout_ready = 1'b1;
        repeat (12) cycle();
        check("bp_n_rd", n_rd, 4);
        check("bp_n_deliv", n_deliv, 4);
        check("bp_burst_cnt", burst_cnt, 1);

        // Flush pulse mid-burst with 6 words present
        do_reset();
        load(6);
        en = 1'b1; dout_ready = 1'b1;
        repeat (2) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        repeat (15) cycle();
        check("fl_n_rd", n_rd, 6);
        check("fl_n_deliv", n_deliv, 6);
        check("fl_burst_cnt", burst_cnt, 0);
        check("fl_busy", busy, 0);

        // Reset asserted mid-burst
        do_reset();
        load(4);
        en = 1'b1; dout_ready = 1'b1;
        repeat (3) cycle();
        check("mr_pre_rdreq", rdreq, 1);
        aclr_n = 1'b0;
        #1;
        check("mr_rdreq", rdreq, 0);
        check("mr_valid", dout_valid, 0);
        check("mr_busy", busy, 0);
        do_reset();
        repeat (3) cycle();
        check("mr_idle_busy", busy, 0);
        check("mr_burst_cnt", burst_cnt, 0);

        // Stale level: burst of 4 started with only 2 words -> underrun
        do_reset();
        load(2);
        force_lvl = BURST;
        update_status();
        en = 1'b1; dout_ready = 1'b1;
        cycle();
        force_lvl = -1;
        update_status();
        repeat (10) cycle();
        check("ur_n_rd", n_rd, 2);
        check("ur_n_deliv", n_deliv, 2);
        check("ur_flag", underrun, 1);
        check("ur_burst_cnt", burst_cnt, 1);
        check("ur_busy", busy, 0);
        repeat (5) cycle();
        check("ur_sticky", underrun, 1);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            en         = ($urandom_range(0, 9) != 0);
            dout_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 99) == 0);
            if (fifo_m.size() < DEPTH && $urandom_range(0, 2) == 0) fifo_write(DW'($urandom()));
            cycle();
        end
        flush = 1'b0; en = 1'b1; dout_ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() > 0; i++) cycle();
        check("rnd_drained", sb.size(), 0);
        repeat (3) cycle();
        check("rnd_busy", busy, 0);
        check("rnd_underrun", underrun, 0);
        check("rnd_rd_eq_deliv", tot_rd, tot_deliv);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
